// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - oversampling UART receiver with majority vote, parity and sticky overrun
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 ready,
  input  logic                 clear_errors,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TDIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TDIV - 1);
  localparam logic [SAMP_W-1:0] SMP_V0   = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] SMP_V1   = SAMP_W'(OVERSAMPLE / 2);
  localparam logic [SAMP_W-1:0] SMP_V2   = SAMP_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SAMP_W-1:0] SMP_LAST = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q, sync3_q;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [SAMP_W-1:0]      samp_q, samp_d;
  logic [BCNT_W-1:0]      bit_q, bit_d;
  logic [1:0]             vote_q, vote_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_acc_q, par_acc_d;
  logic                   perr_frame_q, perr_frame_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  logic tick, at_v0, at_v1, at_v2, bit_end, maj, ovr_event;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // State, counters, shift register and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      samp_q       <= '0;
      bit_q        <= '0;
      vote_q       <= '0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      perr_frame_q <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      samp_q       <= samp_d;
      bit_q        <= bit_d;
      vote_q       <= vote_d;
      shift_q      <= shift_d;
      par_acc_q    <= par_acc_d;
      perr_frame_q <= perr_frame_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      ovr_q        <= ovr_d;
    end
  end

  // Sample timing, bit voting, frame sequencing and handshake next-state
  always_comb begin
    state_d      = state_q;
    samp_d       = samp_q;
    bit_d        = bit_q;
    vote_d       = vote_q;
    shift_d      = shift_q;
    par_acc_d    = par_acc_q;
    perr_frame_d = perr_frame_q;
    data_d       = data_q;
    valid_d      = valid_q;
    perr_d       = perr_q;
    ferr_d       = 1'b0;
    ovr_d        = ovr_q;
    ovr_event    = 1'b0;

    tick    = (div_q == DIV_LAST);
    div_d   = tick ? '0 : div_q + 1'b1;
    at_v0   = tick && (samp_q == SMP_V0);
    at_v1   = tick && (samp_q == SMP_V1);
    at_v2   = tick && (samp_q == SMP_V2);
    bit_end = tick && (samp_q == SMP_LAST);
    // The third vote is the live synchronised line at the last voting tick
    maj     = (vote_q[0] & vote_q[1]) | (vote_q[0] & sync2_q) | (vote_q[1] & sync2_q);

    if (tick) begin
      samp_d = (samp_q == SMP_LAST) ? '0 : samp_q + 1'b1;
    end
    if (at_v0) vote_d[0] = sync2_q;
    if (at_v1) vote_d[1] = sync2_q;

    if (valid_q && ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!sync2_q && sync3_q) begin
          state_d = S_START;
          div_d   = '0;
          samp_d  = '0;
        end
      end
      S_START: begin
        if (at_v2 && maj) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d      = S_DATA;
          bit_d        = '0;
          par_acc_d    = 1'b0;
          perr_frame_d = 1'b0;
        end
      end
      S_DATA: begin
        if (at_v2) begin
          shift_d   = {maj, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ maj;
        end
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (at_v2) begin
          perr_frame_d = (PARITY == 1) ? (par_acc_q ^ maj) : ~(par_acc_q ^ maj);
        end
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        // Decide at the voting point and go idle at once so a prompt next start is caught
        if (at_v2) begin
          state_d = S_IDLE;
          if (!maj) begin
            ferr_d = 1'b1;
          end else if (!valid_q || ready) begin
            data_d  = shift_q;
            perr_d  = (PARITY != 0) ? perr_frame_q : 1'b0;
            valid_d = 1'b1;
          end else begin
            ovr_event = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_errors) ovr_d = 1'b0;
    if (ovr_event)    ovr_d = 1'b1;
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule
